// File: rtl/costas_bpsk_slicer.sv
// BPSK hard-decision slicer behind a Costas loop: sign-change alignment, integrate-and-dump, bit FIFO.
// Optional differential decoding is enabled by defining COSTAS_SLICER_DIFF_DECODE_EN.
module costas_bpsk_slicer #(
  parameter int DATA_W     = 16,
  parameter int SPS        = 20,
  parameter int THRESH     = 4096,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk_main,
  input  logic              rst,
  input  logic              enable,
  input  logic [DATA_W-1:0] i_data,
  input  logic              locked,
  output logic              bit_out,
  output logic              bit_valid,
  input  logic              bit_ready,
  output logic              sym_sync,
  output logic              overflow
);

  localparam int AW = DATA_W + $clog2(SPS) + 1;
  localparam int CW = $clog2(SPS);
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    WAIT_LOCK,
    ACQ,
    TRACK
  } state_t;

  state_t               state_q, state_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 prevSign_q, prevSign_d;
  logic                 prevValid_q, prevValid_d;
  logic                 symSync_q;

  logic signed [AW-1:0] sampleExt;
  logic signed [AW-1:0] sum;
  logic [DATA_W:0]      absVal;
  logic                 sampleSign;
  logic                 qualified;
  logic                 lastSample;
  logic                 decided;
  logic                 pushBit;
  logic                 push;
  logic                 enterTrack;

  assign sampleSign = i_data[DATA_W-1];
  assign sampleExt  = {{(AW-DATA_W){sampleSign}}, i_data};
  // One extra bit so the magnitude of the most negative sample is representable.
  assign absVal     = sampleSign ? (-{1'b1, i_data}) : {1'b0, i_data};
  assign qualified  = (absVal >= (DATA_W+1)'(THRESH));
  assign sum        = acc_q + sampleExt;
  assign lastSample = (cnt_q == CW'(SPS-1));
  assign decided    = ~sum[AW-1];
  assign enterTrack = (state_q == ACQ) && (state_d == TRACK);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    prevSign_d  = prevSign_q;
    prevValid_d = prevValid_q;
    push        = 1'b0;
    case (state_q)
      WAIT_LOCK: begin
        if (locked) state_d = ACQ;
      end
      ACQ: begin
        if (!locked) begin
          state_d     = WAIT_LOCK;
          acc_d       = '0;
          cnt_d       = '0;
          prevSign_d  = 1'b0;
          prevValid_d = 1'b0;
        end else if (enable && qualified) begin
          prevSign_d  = sampleSign;
          prevValid_d = 1'b1;
          if (prevValid_q && (sampleSign != prevSign_q)) begin
            state_d = TRACK;
            acc_d   = sampleExt;
            cnt_d   = CW'(1);
          end
        end
      end
      TRACK: begin
        // Lock loss throws away the partial symbol; the FIFO is left alone.
        if (!locked) begin
          state_d     = WAIT_LOCK;
          acc_d       = '0;
          cnt_d       = '0;
          prevSign_d  = 1'b0;
          prevValid_d = 1'b0;
        end else if (enable) begin
          if (lastSample) begin
            push  = 1'b1;
            acc_d = '0;
            cnt_d = '0;
          end else begin
            acc_d = sum;
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

  always_ff @(posedge clk_main or posedge rst) begin
    if (rst) begin
      state_q     <= WAIT_LOCK;
      acc_q       <= '0;
      cnt_q       <= '0;
      prevSign_q  <= 1'b0;
      prevValid_q <= 1'b0;
      symSync_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      prevSign_q  <= prevSign_d;
      prevValid_q <= prevValid_d;
      symSync_q   <= (state_d == TRACK);
    end
  end

  assign sym_sync = symSync_q;

`ifdef COSTAS_SLICER_DIFF_DECODE_EN
  logic dPrev_q;

  always_ff @(posedge clk_main or posedge rst) begin
    if (rst) begin
      dPrev_q <= 1'b0;
    end else if (enterTrack) begin
      dPrev_q <= 1'b0;
    end else if (push) begin
      dPrev_q <= decided;
    end
  end

  assign pushBit = decided ^ dPrev_q;
`else
  assign pushBit = decided;
`endif

  logic [FIFO_DEPTH-1:0] mem_q;
  logic [PW-1:0]         rdPtr_q, wrPtr_q;
  logic [PW:0]           count_q;
  logic                  overflow_q;
  logic                  pop;
  logic                  full;
  logic                  doPush;

  assign pop    = bit_valid & bit_ready;
  assign full   = (count_q == (PW+1)'(FIFO_DEPTH));
  // A pop on the same edge frees the slot the push needs.
  assign doPush = push & (~full | pop);

  always_ff @(posedge clk_main or posedge rst) begin
    if (rst) begin
      mem_q      <= '0;
      rdPtr_q    <= '0;
      wrPtr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (doPush) begin
        mem_q[wrPtr_q] <= pushBit;
        wrPtr_q        <= wrPtr_q + PW'(1);
      end
      if (pop) rdPtr_q <= rdPtr_q + PW'(1);
      case ({doPush, pop})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
      if (push && !doPush) overflow_q <= 1'b1;
    end
  end

  assign bit_out   = mem_q[rdPtr_q];
  assign bit_valid = (count_q != '0);
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_costas_bpsk_slicer.sv
// Self-checking bench for costas_bpsk_slicer: behavioural model plus scoreboard of decided bits.
module tb_costas_bpsk_slicer;

  localparam int DATA_W     = 16;
  localparam int SPS        = 20;
  localparam int THRESH     = 4096;
  localparam int FIFO_DEPTH = 4;

  logic              clk_main = 1'b0;
  logic              rst;
  logic              enable;
  logic [DATA_W-1:0] i_data;
  logic              locked;
  logic              bit_out;
  logic              bit_valid;
  logic              bit_ready;
  logic              sym_sync;
  logic              overflow;

  int checks   = 0;
  int failures = 0;
  int expQ[$];

  typedef enum {M_WAIT, M_ACQ, M_TRACK} mstate_t;
  mstate_t mState;
  int      mSum;
  int      mCnt;
  int      mCount;
  bit      mPrevSign;
  bit      mPrevValid;
  bit      mOverflow;
  bit      mDPrev;

  costas_bpsk_slicer #(
    .DATA_W(DATA_W), .SPS(SPS), .THRESH(THRESH), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk_main (clk_main),
    .rst      (rst),
    .enable   (enable),
    .i_data   (i_data),
    .locked   (locked),
    .bit_out  (bit_out),
    .bit_valid(bit_valid),
    .bit_ready(bit_ready),
    .sym_sync (sym_sync),
    .overflow (overflow)
  );

  always #5 clk_main = ~clk_main;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Model of one clock edge: lock/acquisition/integration and FIFO occupancy, then output checks.
  task automatic applyStimulus(input logic en, input int val, input logic lk);
    bit popNow;
    bit d;
    bit pb;
    bit sgn;
    int absv;
    enable = en;
    i_data = DATA_W'(val);
    locked = lk;
    popNow = bit_ready && (mCount > 0);
    if (!lk) begin
      mState     = M_WAIT;
      mSum       = 0;
      mCnt       = 0;
      mPrevValid = 0;
    end else begin
      case (mState)
        M_WAIT: mState = M_ACQ;
        M_ACQ: begin
          if (en) begin
            sgn  = (val < 0);
            absv = sgn ? -val : val;
            if (absv >= THRESH) begin
              if (mPrevValid && (sgn != mPrevSign)) begin
                mState = M_TRACK;
                mSum   = val;
                mCnt   = 1;
                mDPrev = 0;
              end
              mPrevSign  = sgn;
              mPrevValid = 1;
            end
          end
        end
        M_TRACK: begin
          if (en) begin
            mSum += val;
            mCnt++;
            if (mCnt == SPS) begin
              d = (mSum >= 0);
`ifdef COSTAS_SLICER_DIFF_DECODE_EN
              pb     = d ^ mDPrev;
              mDPrev = d;
`else
              pb = d;
`endif
              if ((mCount < FIFO_DEPTH) || popNow) begin
                expQ.push_back(int'(pb));
                mCount++;
              end else begin
                mOverflow = 1;
              end
              mSum = 0;
              mCnt = 0;
            end
          end
        end
        default: mState = M_WAIT;
      endcase
    end
    if (popNow) mCount--;
    @(posedge clk_main);
    #2;
    checkOutput("sym_sync", 32'(sym_sync), 32'(mState == M_TRACK));
    checkOutput("bit_valid", 32'(bit_valid), 32'(mCount > 0));
    checkOutput("overflow", 32'(overflow), 32'(mOverflow));
  endtask

  task automatic sendSymbol(input int level);
    for (int k = 0; k < SPS; k++) applyStimulus(1'b1, level, 1'b1);
  endtask

  task automatic sendSplit(input int a, input int b, input int n);
    for (int k = 0; k < SPS; k++) applyStimulus(1'b1, (k < n) ? a : b, 1'b1);
  endtask

  task automatic resetDut();
    rst    = 1'b1;
    enable = 1'b0;
    locked = 1'b0;
    i_data = '0;
    #3;
    checkOutput("rst_bit_valid", 32'(bit_valid), 0);
    checkOutput("rst_sym_sync", 32'(sym_sync), 0);
    checkOutput("rst_overflow", 32'(overflow), 0);
    checkOutput("rst_bit_out", 32'(bit_out), 0);
    mState     = M_WAIT;
    mSum       = 0;
    mCnt       = 0;
    mCount     = 0;
    mPrevSign  = 0;
    mPrevValid = 0;
    mOverflow  = 0;
    mDPrev     = 0;
    expQ.delete();
    @(posedge clk_main);
    #2;
    rst = 1'b0;
  endtask

  // Scoreboard consumer: a pop happens on the next rising edge whenever valid and ready are seen here.
  always @(negedge clk_main) begin
    if (!rst && bit_valid && bit_ready) begin
      checkOutput("sb_has_entry", 32'(expQ.size() > 0), 1);
      if (expQ.size() > 0) checkOutput("bit_out", 32'(bit_out), 32'(expQ.pop_front()));
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    enable    = 1'b0;
    locked    = 1'b0;
    i_data    = '0;
    bit_ready = 1'b1;
    resetDut();

    // Idle: no lock, samples ignored.
    for (int i = 0; i < 60; i++) applyStimulus(1'b1, (((i / 20) % 2) != 0) ? -20000 : 20000, 1'b0);
    checkOutput("idle_sym_sync", 32'(sym_sync), 0);

    // Acquire on the first negative sample after a positive run, then alternate.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 20000, 1'b1);
    checkOutput("acq_pre_sync", 32'(sym_sync), 0);
    applyStimulus(1'b1, -20000, 1'b1);
    checkOutput("acq_sync_rise", 32'(sym_sync), 1);
    for (int k = 1; k < SPS; k++) applyStimulus(1'b1, -20000, 1'b1);
    for (int s = 0; s < 5; s++) sendSymbol(((s % 2) == 0) ? 20000 : -20000);

    // Integration boundaries and enable gaps mid-symbol.
    sendSplit(100, -100, 10);
    sendSplit(99, -100, 10);
    sendSplit(3000, -2000, 10);
    for (int k = 0; k < 7; k++) applyStimulus(1'b1, -7, 1'b1);
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 30000, 1'b1);
    for (int k = 7; k < SPS; k++) applyStimulus(1'b1, -7, 1'b1);
    sendSplit(-32768, 32767, 1);

    // Backpressure: six decisions into a four-deep FIFO.
    bit_ready = 1'b0;
    for (int s = 0; s < 6; s++) sendSymbol(((s % 2) == 0) ? 15000 : -15000);
    checkOutput("bp_overflow", 32'(overflow), 1);

    // Lock loss mid-symbol; buffered bits must survive.
    for (int k = 0; k < 10; k++) applyStimulus(1'b1, 20000, 1'b1);
    applyStimulus(1'b1, 20000, 1'b0);
    checkOutput("lockloss_sync", 32'(sym_sync), 0);
    checkOutput("lockloss_fifo", 32'(bit_valid), 1);
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, 20000, 1'b0);
    bit_ready = 1'b1;
    for (int k = 0; k < 8; k++) applyStimulus(1'b0, 0, 1'b0);
    checkOutput("drain_empty", 32'(expQ.size()), 0);
    checkOutput("drain_overflow_sticky", 32'(overflow), 1);

    // Threshold: sub-threshold swings must not trigger acquisition.
    applyStimulus(1'b1, 5000, 1'b1);
    applyStimulus(1'b1, 5000, 1'b1);
    for (int k = 0; k < 12; k++) applyStimulus(1'b1, ((k % 2) == 0) ? 1000 : -1000, 1'b1);
    applyStimulus(1'b1, 5000, 1'b1);
    checkOutput("thresh_hold", 32'(sym_sync), 0);
    applyStimulus(1'b1, -5000, 1'b1);
    checkOutput("thresh_sync", 32'(sym_sync), 1);
    for (int k = 1; k < SPS; k++) applyStimulus(1'b1, -5000, 1'b1);

    // Symbol sequence +,+,-,-,+ and then its inverse after reacquiring.
    sendSymbol(20000);
    sendSymbol(20000);
    sendSymbol(-20000);
    sendSymbol(-20000);
    sendSymbol(20000);
    applyStimulus(1'b1, 20000, 1'b0);
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, 20000, 1'b1);
    sendSymbol(-20000);
    sendSymbol(-20000);
    sendSymbol(20000);
    sendSymbol(20000);
    sendSymbol(-20000);
    for (int k = 0; k < 4; k++) applyStimulus(1'b0, 0, 1'b1);
    checkOutput("seq_drained", 32'(expQ.size()), 0);

    // Mid-operation reset clears buffered bits.
    bit_ready = 1'b0;
    sendSymbol(-20000);
    sendSymbol(20000);
    resetDut();
    bit_ready = 1'b1;
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, 20000, 1'b0);
    checkOutput("post_rst_valid", 32'(bit_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
